// File: rtl/tdm_transmit.sv
// tdm_transmit: serializes four audio samples onto a 4-slot TDM bus.
// sck is divided from clk_in; ws/sd/state advance on sck falling ticks.
module tdm_transmit #(
  parameter int BIT_WIDTH  = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int SLOTS      = 4,
  parameter int SCK_DIV    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic [BIT_WIDTH-1:0] audio_in1,
  input  logic [BIT_WIDTH-1:0] audio_in2,
  input  logic [BIT_WIDTH-1:0] audio_in3,
  input  logic [BIT_WIDTH-1:0] audio_in4,
  input  logic                 audio_valid_in,
  output logic                 ready_out,
  output logic                 sck,
  output logic                 ws,
  output logic                 sd,
  output logic                 busy_out
);

  localparam int BW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [1:0]    SLOT_LAST = 2'(SLOTS - 1);
  localparam int MSB = BIT_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA
  } state_e;

  typedef logic [BIT_WIDTH-1:0] word_t;

  state_e      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic        sck_q, sck_d;
  logic        ws_q, ws_d;
  logic        sd_q, sd_d;
  logic        pend_q, pend_d;
  word_t       hold_q [4];
  word_t       hold_d [4];
  word_t       sh_q [4];
  word_t       sh_d [4];
  word_t       cur_q, cur_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [1:0]  slot_q, slot_d;

  logic        term;
  logic        fall;
  logic        load;
  logic        hs;
  logic [1:0]  nslot;

  always_comb begin
    state_d = state_q;
    div_d   = div_q + DIV_ONE;
    sck_d   = sck_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    sh_d    = sh_q;
    cur_d   = cur_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    load    = 1'b0;
    nslot   = slot_q + 2'd1;
    term    = (div_q == DIV_LAST);
    fall    = term & sck_q;
    hs      = audio_valid_in & ~pend_q;

    if (term) begin
      div_d = '0;
      sck_d = ~sck_q;
    end

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          ws_d = 1'b0;
          sd_d = 1'b0;
          if (pend_q) begin
            load    = 1'b1;
            ws_d    = 1'b1;
            state_d = SYNC;
          end
        end
        SYNC: begin
          ws_d    = 1'b0;
          sd_d    = sh_q[0][MSB];
          cur_d   = sh_q[0] << 1;
          bit_d   = '0;
          slot_d  = '0;
          state_d = DATA;
        end
        DATA: begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (slot_q == SLOT_LAST) begin
              sd_d    = 1'b0;
              state_d = IDLE;
              if (pend_q) begin
                load    = 1'b1;
                ws_d    = 1'b1;
                state_d = SYNC;
              end
            end else begin
              slot_d = nslot;
              sd_d   = sh_q[nslot][MSB];
              cur_d  = sh_q[nslot] << 1;
            end
          end else begin
            // cur shifts in zeros, so slot padding falls out naturally
            bit_d = bit_q + BIT_ONE;
            sd_d  = cur_q[MSB];
            cur_d = cur_q << 1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      sh_d   = hold_q;
      pend_d = 1'b0;
    end
    if (hs) begin
      hold_d[0] = audio_in1;
      hold_d[1] = audio_in2;
      hold_d[2] = audio_in3;
      hold_d[3] = audio_in4;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      pend_q  <= 1'b0;
      cur_q   <= '0;
      bit_q   <= '0;
      slot_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= '0;
        sh_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      hold_q  <= hold_d;
      sh_q    <= sh_d;
    end
  end

  assign sck       = sck_q;
  assign ws        = ws_q;
  assign sd        = sd_q;
  assign ready_out = ~pend_q;
  assign busy_out  = (state_q != IDLE);

endmodule

// File: tb/tb_tdm_transmit.sv
// Bench for tdm_transmit: directed frames decoded by a bench-side
// receiver sampling sd on sck rising edges.
module tb_tdm_transmit;

  logic        clk_in = 1'b0;
  logic        rst_in_n = 1'b0;
  logic [23:0] a1 = '0, a2 = '0, a3 = '0, a4 = '0;
  logic        valid = 1'b0;
  logic        ready_out, sck, ws, sd, busy_out;

  always #5 clk_in = ~clk_in;

  tdm_transmit dut (
    .clk_in         (clk_in),
    .rst_in_n       (rst_in_n),
    .audio_in1      (a1),
    .audio_in2      (a2),
    .audio_in3      (a3),
    .audio_in4      (a4),
    .audio_valid_in (valid),
    .ready_out      (ready_out),
    .sck            (sck),
    .ws             (ws),
    .sd             (sd),
    .busy_out       (busy_out)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [127:0] rx_sr = '0;
  int           rx_cnt = 0;
  logic [127:0] frames [$];
  longint       ws_t [$];

  always @(posedge sck or negedge rst_in_n) begin
    if (!rst_in_n) begin
      rx_cnt = 0;
    end else begin
      if (rx_cnt > 0) begin
        rx_sr = {rx_sr[126:0], sd};
        rx_cnt--;
        if (rx_cnt == 0) frames.push_back(rx_sr);
      end
      if (ws) begin
        rx_cnt = 128;
        ws_t.push_back(longint'($time));
      end
    end
  end

  function automatic logic [127:0] frm(input logic [23:0] b1, b2, b3, b4);
    return {b1, 8'h0, b2, 8'h0, b3, 8'h0, b4, 8'h0};
  endfunction

  task automatic send(input logic [23:0] b1, b2, b3, b4, input string tag);
    int t = 0;
    @(negedge clk_in);
    while (!ready_out && t < 4000) begin
      @(negedge clk_in);
      t++;
    end
    chk({tag, "_rdy"}, 128'(ready_out), 128'(1));
    a1 = b1; a2 = b2; a3 = b3; a4 = b4;
    valid = 1'b1;
    @(negedge clk_in);
    valid = 1'b0;
    chk({tag, "_rdy_lo"}, 128'(ready_out), 128'(0));
  endtask

  task automatic send_bp(output logic [23:0] c1, c2, c3, c4,
                         output int waited);
    int  t = 0;
    logic done = 1'b0;
    while (!done && t < 4000) begin
      @(negedge clk_in);
      a1 = 24'h0A0000 ^ 24'(t);
      a2 = 24'hFF0000 - 24'(t);
      a3 = 24'(t * 3 + 5);
      a4 = 24'h5A5A00 | 24'(t);
      valid = 1'b1;
      if (ready_out) begin
        c1 = a1; c2 = a2; c3 = a3; c4 = a4;
        done = 1'b1;
      end
      t++;
    end
    waited = t;
    @(negedge clk_in);
    valid = 1'b0;
    chk("bp_rdy_lo", 128'(ready_out), 128'(0));
  endtask

  task automatic wait_frames(input int n, input string tag);
    int t = 0;
    while (frames.size() < n && t < 8000) begin
      @(negedge clk_in);
      t++;
    end
    chk(tag, 128'(frames.size()), 128'(n));
  endtask

  logic [23:0]  c1, c2, c3, c4;
  logic [23:0]  r [4];
  logic [127:0] exp_q [$];
  logic [7:0]   sv;
  logic         seen;
  int           lat, wid, bpw;

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_outs", 128'({sck, ws, sd, busy_out}), 128'(0));
    chk("rst_ready", 128'(ready_out), 128'(1));
    rst_in_n = 1'b1;
    sv = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      sv = {sv[6:0], sck};
    end
    chk("sck_div", 128'(sv), 128'(8'b0110_0110));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      seen = seen | ws | sd | busy_out;
    end
    chk("idle_quiet", 128'(seen), 128'(0));

    // single frame
    send(24'hA5A5A5, 24'h123456, 24'h800001, 24'hFFFFFF, "single");
    lat = 0;
    while (!ws && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    chk("ws_latency", 128'(lat >= 1 && lat <= 4), 128'(1));
    chk("busy_with_ws", 128'(busy_out), 128'(1));
    wid = 0;
    while (ws && wid < 20) begin
      @(negedge clk_in);
      wid++;
    end
    chk("ws_width", 128'(wid), 128'(4));
    wait_frames(1, "single_cnt");
    if (frames.size() > 0)
      chk("single_data", frames[0],
          frm(24'hA5A5A5, 24'h123456, 24'h800001, 24'hFFFFFF));
    repeat (8) @(negedge clk_in);
    chk("single_end", 128'({busy_out, ready_out, sd, ws}), 128'(4'b0100));

    // back-to-back plus backpressure
    frames.delete();
    ws_t.delete();
    send(24'h111111, 24'h222222, 24'h333333, 24'h444444, "b2b_a");
    send(24'hC0FFEE, 24'h0BADF0, 24'h7FFFFF, 24'h000001, "b2b_b");
    send_bp(c1, c2, c3, c4, bpw);
    chk("bp_waited", 128'(bpw > 400), 128'(1));
    wait_frames(3, "b2b_cnt");
    if (frames.size() >= 3) begin
      chk("b2b_f0", frames[0],
          frm(24'h111111, 24'h222222, 24'h333333, 24'h444444));
      chk("b2b_f1", frames[1],
          frm(24'hC0FFEE, 24'h0BADF0, 24'h7FFFFF, 24'h000001));
      chk("bp_f2", frames[2], frm(c1, c2, c3, c4));
    end
    if (ws_t.size() >= 3) begin
      chk("ws_gap01", 128'(ws_t[1] - ws_t[0]), 128'(5160));
      chk("ws_gap12", 128'(ws_t[2] - ws_t[1]), 128'(5160));
    end else begin
      chk("ws_cnt", 128'(ws_t.size()), 128'(3));
    end
    repeat (10) @(negedge clk_in);

    // reset in the middle of slot 2
    send(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, "mid");
    lat = 0;
    while (!ws && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    repeat (276) @(negedge clk_in);
    chk("pre_rst", 128'({busy_out, sd}), 128'(2'b11));
    @(posedge clk_in);
    #2 rst_in_n = 1'b0;
    #1;
    chk("mid_rst_outs", 128'({sck, ws, sd, busy_out}), 128'(0));
    chk("mid_rst_ready", 128'(ready_out), 128'(1));
    frames.delete();
    ws_t.delete();
    repeat (3) @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (600) @(negedge clk_in);
    chk("post_rst_frames", 128'(frames.size() + ws_t.size()), 128'(0));
    chk("post_rst_idle", 128'({busy_out, ready_out, sd}), 128'(3'b010));

    // streamed random frames
    frames.delete();
    ws_t.delete();
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 4; k++) r[k] = 24'($urandom);
      exp_q.push_back(frm(r[0], r[1], r[2], r[3]));
      send(r[0], r[1], r[2], r[3], "rnd");
    end
    wait_frames(12, "rnd_cnt");
    for (int i = 0; i < 12; i++)
      if (i < frames.size())
        chk($sformatf("rnd_f%0d", i), frames[i], exp_q[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
